myo_pwm_driver: RTL and testbench
=================================

// Module: myo_pwm_driver
// PURPOSE
//  Downstream stage of the PID controller. Consumes the signed 16-bit PWM reference.
//  Produces the two H-bridge inputs (in1 = forward, in2 = reverse) for one motor.
//  Duty magnitude is |ref|, direction is sign(ref). Updates are double-buffered to PWM
//  period boundaries, and a dead-time is inserted on every direction reversal.
//  Instantiated once per motor, next to the PID controller, on the same clock.
// PARAMETERS
//  PERIOD        2500  PWM period in clock cycles (20 kHz at 50 MHz); legal 2..65535
//  DEADTIME      50    cycles with both outputs low on a direction reversal; legal 1..65535
//  WATCHDOG_PER  100   PWM periods without pwm_ref_valid before fault (WATCHDOG_EN only)
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  enable         in   1   0 = coast (in1=in2=0), counter keeps running
//  pwm_ref        in   16  signed duty reference, units = clock cycles of on-time
//  pwm_ref_valid  in   1   one-cycle strobe: capture pwm_ref into shadow register
//  in1            out  1   H-bridge forward input
//  in2            out  1   H-bridge reverse input
//  period_start   out  1   one-cycle pulse when the period counter is 0
//  in_deadtime    out  1   high while the dead-time state is active
//  fault          out  1   watchdog timeout flag, sticky (0 when WATCHDOG_EN undefined)
// BEHAVIOUR
//  Reset: cnt=0, shadow=0, active duty=0, dir=fwd, state=RUN, all outputs 0.
//  Counter: cnt runs 0..PERIOD-1 and wraps; it is held at 0 only during DEADTIME.
//  period_start = (cnt==0) while state==RUN.
//  Shadow: on pwm_ref_valid, shadow<=pwm_ref. Multiple strobes within a period: the last one wins.
//  A strobe in the same cycle as the wrap is taken at this wrap (bypass: shadow_next is used).
//  Magnitude: mag = |shadow|, computed 17 bits wide so that -32768 gives 32768.
//  Clamp: duty = min(mag, PERIOD).
//  Latch at wrap (cnt==PERIOD-1), or continuously while duty_act==0:
//   - new dir == dir, or new duty == 0: duty_act<=duty, dir<=new dir, cnt->0.
//   - new dir != dir and new duty != 0: enter DEADTIME.
//  States:
//   RUN: in1 = enable & dir==fwd & (cnt < duty_act); in2 = same for rev.
//   DEADTIME: in1=in2=0; a counter runs DEADTIME cycles; then dir flips, duty_act latches,
//    cnt=0, state goes to RUN. A shadow write during DEADTIME is reconsidered at exit.
//    If its sign matches the old dir, the flip is cancelled.
//  Boundaries:
//   - duty_act==0: both outputs low for the whole period.
//   - duty_act==PERIOD: output high for all PERIOD cycles.
//   - ref==0 keeps the current dir; no dead-time is ever taken for zero.
//  Invariant: in1 & in2 is never 1, in any cycle, under any stimulus.
//  Outputs are registered and aligned to cnt, so the first high cycle is the period_start cycle.
//  Reset asserted mid-period or in DEADTIME: next cycle, all outputs are 0 and the reset state holds.
//  enable low: outputs are forced 0 immediately (next edge); the latch/state logic continues.
// CONFIGURATION
//  WATCHDOG_EN defined:
//   - per-period counter cleared by pwm_ref_valid; after WATCHDOG_PER wraps with no strobe, fault<=1.
//   - fault forces in1=in2=0 and clears shadow to 0.
//   - fault is cleared only by reset.
//  WATCHDOG_EN undefined: no watchdog logic; fault is tied 0.
// TESTING  (bench: PERIOD=100, DEADTIME=5, WATCHDOG_PER=3)
//  1 reset, enable=1, ref=+40 strobe -> from the next period_start, in1 high 40 of every 100 cycles; in2=0.
//  2 ref=+40 then strobe ref=-30 mid-period -> current period finishes at 40; 5 cycles both low, in_deadtime=1;
//    then in2 high 30/100.
//  3 ref=-32768 -> in2 high 100/100 continuously; ref=+150 -> dead-time, then in1 stuck high.
//  4 two strobes in one period (+10, +70) -> next period high 70; ref=0 -> both low, no dead-time.
//  5 reset pulsed during DEADTIME and mid-period -> in1=in2=0, period_start=0 the next cycle.
//    Assertion: in1&in2 is never set, in any test.
//  6 WATCHDOG_EN: no strobe for 3 periods -> fault=1, outputs 0; a strobe does not clear it; reset clears it.

Source files
------------

// File: rtl/myo_pwm_driver_if.sv
// myo_pwm_driver_if: control and H-bridge signals of one motor PWM driver.
`default_nettype none

interface myo_pwm_driver_if;
  logic        enable;
  logic [15:0] pwm_ref;
  logic        pwm_ref_valid;
  logic        in1;
  logic        in2;
  logic        period_start;
  logic        in_deadtime;
  logic        fault;

  modport master (
    output enable, pwm_ref, pwm_ref_valid,
    input  in1, in2, period_start, in_deadtime, fault
  );

  modport slave (
    input  enable, pwm_ref, pwm_ref_valid,
    output in1, in2, period_start, in_deadtime, fault
  );
endinterface

`default_nettype wire

// File: rtl/myo_pwm_driver.sv
// myo_pwm_driver: sign/magnitude H-bridge PWM with period-aligned updates and reversal dead-time.
// Optional watchdog enabled by defining WATCHDOG_EN.
`default_nettype none

module myo_pwm_driver #(
  parameter int PERIOD       = 2500,
  parameter int DEADTIME     = 50,
  parameter int WATCHDOG_PER = 100
) (
  input  wire logic        clock,
  input  wire logic        reset,
  myo_pwm_driver_if.slave  bus
);

  if (PERIOD < 2 || PERIOD > 65535) begin : g_bad_period
    $error("PERIOD out of range");
  end
  if (DEADTIME < 1 || DEADTIME > 65535) begin : g_bad_deadtime
    $error("DEADTIME out of range");
  end
  if (WATCHDOG_PER < 1 || WATCHDOG_PER > 65535) begin : g_bad_wdper
    $error("WATCHDOG_PER out of range");
  end

  localparam logic [15:0] CNT_MAX  = 16'(PERIOD - 1);
  localparam logic [15:0] DT_MAX   = 16'(DEADTIME - 1);
  localparam logic [16:0] PERIOD_W = 17'(PERIOD);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DEAD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dt_q, dt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [16:0] duty_act_q, duty_act_d;
  logic        dir_q, dir_d;
  logic        fault_q, fault_d;
  logic        in1_q, in1_d, in2_q, in2_d;
  logic        ps_q, ps_d, indt_q, indt_d;

  logic [16:0] mag, duty;
  logic        new_dir, wrap, on;

`ifdef WATCHDOG_EN
  localparam logic [15:0] WD_MAX = 16'(WATCHDOG_PER - 1);
  logic [15:0] wd_q, wd_d;
`endif

  always_comb begin
    shadow_d = shadow_q;
    if (fault_q)
      shadow_d = '0;
    else if (bus.pwm_ref_valid)
      shadow_d = bus.pwm_ref;

    // 17-bit magnitude so that -32768 maps to +32768 before clamping.
    mag     = shadow_d[15] ? ({1'b0, ~shadow_d} + 17'd1) : {1'b0, shadow_d};
    duty    = (mag > PERIOD_W) ? PERIOD_W : mag;
    new_dir = (shadow_d == '0) ? dir_q : shadow_d[15];
    wrap    = (state_q == ST_RUN) && (cnt_q == CNT_MAX);

    state_d    = state_q;
    cnt_d      = cnt_q;
    dt_d       = dt_q;
    duty_act_d = duty_act_q;
    dir_d      = dir_q;

    case (state_q)
      ST_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + 16'd1;
        if (wrap || (duty_act_q == '0 && duty != '0)) begin
          cnt_d = '0;
          if (new_dir == dir_q || duty == '0) begin
            duty_act_d = duty;
            dir_d      = new_dir;
          end else begin
            state_d = ST_DEAD;
            dt_d    = '0;
          end
        end
      end
      ST_DEAD: begin
        cnt_d = '0;
        // Shadow is re-evaluated at exit, so a same-sign rewrite cancels the flip.
        if (dt_q == DT_MAX) begin
          state_d    = ST_RUN;
          duty_act_d = duty;
          dir_d      = new_dir;
        end else begin
          dt_d = dt_q + 16'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    fault_d = fault_q;
`ifdef WATCHDOG_EN
    wd_d = wd_q;
    if (bus.pwm_ref_valid)
      wd_d = '0;
    else if (wrap && !fault_q) begin
      if (wd_q == WD_MAX)
        fault_d = 1'b1;
      else
        wd_d = wd_q + 16'd1;
    end
`else
    fault_d = 1'b0;
`endif

    on     = (state_d == ST_RUN) && bus.enable && !fault_d && ({1'b0, cnt_d} < duty_act_d);
    in1_d  = on && !dir_d;
    in2_d  = on && dir_d;
    ps_d   = (state_d == ST_RUN) && (cnt_d == '0);
    indt_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      dt_q       <= '0;
      shadow_q   <= '0;
      duty_act_q <= '0;
      dir_q      <= 1'b0;
      fault_q    <= 1'b0;
      in1_q      <= 1'b0;
      in2_q      <= 1'b0;
      ps_q       <= 1'b0;
      indt_q     <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dt_q       <= dt_d;
      shadow_q   <= shadow_d;
      duty_act_q <= duty_act_d;
      dir_q      <= dir_d;
      fault_q    <= fault_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      ps_q       <= ps_d;
      indt_q     <= indt_d;
`ifdef WATCHDOG_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign bus.in1          = in1_q;
  assign bus.in2          = in2_q;
  assign bus.period_start = ps_q;
  assign bus.in_deadtime  = indt_q;
  assign bus.fault        = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_myo_pwm_driver.sv
// tb_myo_pwm_driver: directed and random stimulus against a behavioural period/dead-time model.
`default_nettype none

module tb_myo_pwm_driver;
  localparam int P = 100;
  localparam int D = 5;
  localparam int W = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  myo_pwm_driver_if bus ();

  myo_pwm_driver #(.PERIOD(P), .DEADTIME(D), .WATCHDOG_PER(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: position in period, remaining dead cycles, active duty and direction.
  int m_cnt = 0, m_shadow = 0, m_duty = 0, m_dir = 0, m_dead = 0, m_wd = 0;
  bit m_fault = 0;
  bit e_in1 = 0, e_in2 = 0, e_ps = 0, e_dt = 0;

  task automatic model_step();
    int sh, want, wdir;
    bit wrap, run, on;
    if (reset) begin
      m_cnt = 0; m_shadow = 0; m_duty = 0; m_dir = 0; m_dead = 0; m_wd = 0; m_fault = 0;
      e_in1 = 0; e_in2 = 0; e_ps = 0; e_dt = 0;
      return;
    end
    sh   = m_fault ? 0 : (bus.pwm_ref_valid ? int'($signed(bus.pwm_ref)) : m_shadow);
    want = (sh < 0) ? -sh : sh;
    if (want > P) want = P;
    wdir = (sh == 0) ? m_dir : ((sh < 0) ? 1 : 0);
    wrap = (m_dead == 0) && (m_cnt == P - 1);
`ifdef WATCHDOG_EN
    if (bus.pwm_ref_valid) m_wd = 0;
    else if (wrap && !m_fault) begin
      m_wd++;
      if (m_wd == W) m_fault = 1;
    end
`endif
    m_shadow = sh;
    if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        m_duty = want;
        m_dir  = wdir;
      end
    end else if (wrap || (m_duty == 0 && want != 0)) begin
      m_cnt = 0;
      if (wdir == m_dir || want == 0) m_duty = want;
      else m_dead = D;
    end else begin
      m_cnt++;
    end
    run   = (m_dead == 0);
    on    = run && bus.enable && !m_fault && (m_cnt < m_duty);
    e_in1 = on && (m_dir == 0);
    e_in2 = on && (m_dir == 1);
    e_ps  = run && (m_cnt == 0);
    e_dt  = !run;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    chk("in1", bus.in1, e_in1);
    chk("in2", bus.in2, e_in2);
    chk("period_start", bus.period_start, e_ps);
    chk("in_deadtime", bus.in_deadtime, e_dt);
    chk("fault", bus.fault, m_fault);
  endtask

  task automatic strobe(input int v);
    bus.pwm_ref       = 16'(v);
    bus.pwm_ref_valid = 1'b1;
    cycle();
    bus.pwm_ref_valid = 1'b0;
  endtask

  task automatic count_period(output int n1, output int n2, output int ndt);
    int guard = 0;
    ndt = 0;
    while (!bus.period_start && guard < 300) begin
      ndt += int'(bus.in_deadtime);
      cycle();
      guard++;
    end
    chk("period_start_seen", 32'(guard < 300), 1);
    n1 = 0;
    n2 = 0;
    for (int k = 0; k < P; k++) begin
      n1  += int'(bus.in1);
      n2  += int'(bus.in2);
      ndt += int'(bus.in_deadtime);
      cycle();
    end
  endtask

  always @(negedge clock) chk("exclusive", 32'(bus.in1 & bus.in2), 0);

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n1, n2, ndt;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.pwm_ref = '0;
    bus.pwm_ref_valid = 1'b0;
    repeat (3) cycle();
    chk("rst_in1", bus.in1, 0);
    chk("rst_ps", bus.period_start, 0);
    reset = 1'b0;
    bus.enable = 1'b1;
    repeat (4) cycle();

    strobe(40);
    count_period(n1, n2, ndt);
    chk("t1_in1_count", n1, 40);
    chk("t1_in2_count", n2, 0);
    chk("t1_dead", ndt, 0);

    repeat (20) cycle();
    strobe(-30);
    count_period(n1, n2, ndt);
    chk("t2_in1_count", n1, 0);
    chk("t2_in2_count", n2, 30);
    chk("t2_dead", ndt, D);

    strobe(-32768);
    count_period(n1, n2, ndt);
    chk("t3_in2_full", n2, P);
    strobe(150);
    count_period(n1, n2, ndt);
    chk("t3_in1_full", n1, P);
    chk("t3_in2_zero", n2, 0);
    chk("t3_dead", ndt, D);

    count_period(n1, n2, ndt);
    strobe(10);
    repeat (5) cycle();
    strobe(70);
    count_period(n1, n2, ndt);
    chk("t4_last_wins", n1, 70);
    strobe(0);
    count_period(n1, n2, ndt);
    chk("t4_zero_in1", n1, 0);
    chk("t4_zero_in2", n2, 0);
    chk("t4_zero_dead", ndt, 0);

    strobe(-50);
    repeat (2) cycle();
    chk("t5_in_dead", bus.in_deadtime, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_dt_rst_in1", bus.in1, 0);
    chk("t5_dt_rst_in2", bus.in2, 0);
    chk("t5_dt_rst_ps", bus.period_start, 0);
    chk("t5_dt_rst_dt", bus.in_deadtime, 0);
    strobe(40);
    repeat (30) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_mid_rst_in1", bus.in1, 0);
    chk("t5_mid_rst_ps", bus.period_start, 0);
    repeat (3) cycle();

    for (int i = 0; i < 3000; i++) begin
      bus.pwm_ref_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0: bus.pwm_ref = 16'h0000;
        1: bus.pwm_ref = 16'h8000;
        2: bus.pwm_ref = 16'h7FFF;
        3: bus.pwm_ref = 16'($signed($urandom_range(0, 240)) - 120);
        default: bus.pwm_ref = 16'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
      reset = ($urandom_range(0, 999) == 0);
      cycle();
    end
    bus.pwm_ref_valid = 1'b0;
    bus.enable = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    strobe(40);
    repeat (400) cycle();
`ifdef WATCHDOG_EN
    chk("t6_fault_set", bus.fault, 1);
    strobe(40);
    repeat (200) cycle();
    chk("t6_fault_sticky", bus.fault, 1);
    chk("t6_fault_in1", bus.in1, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_fault_clear", bus.fault, 0);
`else
    chk("t6_no_fault", bus.fault, 0);
`endif
    repeat (5) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
